// File: rtl/minimig_bank_pkg.sv
// Shared types and constants for the Minimig bank responder: FSM states,
// bank bit positions, ROM write-protect mask and default timeout.
package minimig_bank_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam int BANK_W = 8;
    localparam int IDX_W  = 3;

    localparam int BANK_KICK    = 7;
    localparam int BANK_KICKEXT = 6;
    localparam int BANK_CHIP    = 5;
    localparam int BANK_SLOW    = 4;

    localparam logic [BANK_W-1:0] ROM_WP_MASK = 8'hC0;

    localparam int DEFAULT_TIMEOUT = 255;

    // Read data returned when the memory controller never answers.
    localparam logic [15:0] TIMEOUT_RDATA = 16'hFFFF;

    function automatic logic is_rom_bank(input logic [BANK_W-1:0] bank);
        return (bank & ROM_WP_MASK) != '0;
    endfunction

endpackage

// File: rtl/minimig_bank_responder_if.sv
// Bus-side access and memory-controller signals of the bank responder.
// The master modport is the bus/memory environment, slave is the responder.
interface minimig_bank_responder_if;

    logic        req;
    logic [7:0]  bank;
    logic [17:0] addr;
    logic        we;
    logic [1:0]  bsel;
    logic [15:0] wdata;
    logic        rom_wp;
    logic        busy;
    logic        ack;
    logic        err;
    logic [15:0] rdata;

    logic        mem_req;
    logic [20:0] mem_addr;
    logic        mem_we;
    logic [1:0]  mem_bsel;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;

    modport master (
        output req, bank, addr, we, bsel, wdata, rom_wp, mem_ack, mem_rdata,
        input  busy, ack, err, rdata, mem_req, mem_addr, mem_we, mem_bsel, mem_wdata
    );

    modport slave (
        input  req, bank, addr, we, bsel, wdata, rom_wp, mem_ack, mem_rdata,
        output busy, ack, err, rdata, mem_req, mem_addr, mem_we, mem_bsel, mem_wdata
    );

endinterface

// File: rtl/minimig_bank_onehot_enc.sv
// Combinational one-hot bank select to 3-bit index; valid only when exactly
// one bit is set.
module minimig_bank_onehot_enc
    import minimig_bank_pkg::*;
(
    input  logic [BANK_W-1:0] onehot,
    output logic [IDX_W-1:0]  index,
    output logic              valid
);

    always_comb begin
        index = '0;
        // OR-encoding is exact for one-hot input; garbage otherwise, masked by valid.
        for (int i = 0; i < BANK_W; i++) begin
            if (onehot[i]) begin
                index = index | IDX_W'(i);
            end
        end
        valid = (onehot != '0) && ((onehot & (onehot - 8'd1)) == '0);
    end

endmodule

// File: rtl/minimig_bank_responder.sv
// Accepts a one-hot bank qualified bus access, issues one request to the
// memory controller and returns data/ack/err, with ROM protect and timeout.
module minimig_bank_responder
    import minimig_bank_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      reset,
    minimig_bank_responder_if.slave   bus
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [7:0]  cnt, cnt_nxt;

    logic        busy_r, busy_nxt;
    logic        ack_r, ack_nxt;
    logic        err_r, err_nxt;
    logic [15:0] rdata_r, rdata_nxt;
    logic        mem_req_r, mem_req_nxt;
    logic [20:0] mem_addr_r, mem_addr_nxt;
    logic        mem_we_r, mem_we_nxt;
    logic [1:0]  mem_bsel_r, mem_bsel_nxt;
    logic [15:0] mem_wdata_r, mem_wdata_nxt;

    logic [IDX_W-1:0] bank_idx;
    logic             bank_valid;
    logic             blocked;

    minimig_bank_onehot_enc u_enc (
        .onehot (bus.bank),
        .index  (bank_idx),
        .valid  (bank_valid)
    );

    assign blocked = bus.we && bus.rom_wp && is_rom_bank(bus.bank);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            busy_r      <= 1'b0;
            ack_r       <= 1'b0;
            err_r       <= 1'b0;
            rdata_r     <= '0;
            mem_req_r   <= 1'b0;
            mem_addr_r  <= '0;
            mem_we_r    <= 1'b0;
            mem_bsel_r  <= '0;
            mem_wdata_r <= '0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            busy_r      <= busy_nxt;
            ack_r       <= ack_nxt;
            err_r       <= err_nxt;
            rdata_r     <= rdata_nxt;
            mem_req_r   <= mem_req_nxt;
            mem_addr_r  <= mem_addr_nxt;
            mem_we_r    <= mem_we_nxt;
            mem_bsel_r  <= mem_bsel_nxt;
            mem_wdata_r <= mem_wdata_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        ack_nxt       = 1'b0;
        err_nxt       = 1'b0;
        rdata_nxt     = rdata_r;
        mem_req_nxt   = 1'b0;
        mem_addr_nxt  = mem_addr_r;
        mem_we_nxt    = mem_we_r;
        mem_bsel_nxt  = mem_bsel_r;
        mem_wdata_nxt = mem_wdata_r;

        case (state)
            ST_IDLE: begin
                if (bus.req) begin
                    mem_addr_nxt  = {bank_idx, bus.addr};
                    mem_we_nxt    = bus.we;
                    mem_bsel_nxt  = bus.bsel;
                    mem_wdata_nxt = bus.wdata;
                    cnt_nxt       = '0;
                    if (!bank_valid || blocked) begin
                        state_nxt = ST_RESP;
                        ack_nxt   = 1'b1;
                        err_nxt   = 1'b1;
                    end else begin
                        state_nxt   = ST_ACCESS;
                        mem_req_nxt = 1'b1;
                    end
                end
            end
            ST_ACCESS: begin
                // mem_ack takes priority over a timeout in the same cycle.
                if (bus.mem_ack) begin
                    state_nxt = ST_RESP;
                    ack_nxt   = 1'b1;
                    if (!mem_we_r) begin
                        rdata_nxt = bus.mem_rdata;
                    end
                end else if (cnt == TO_LAST) begin
                    state_nxt = ST_RESP;
                    ack_nxt   = 1'b1;
                    err_nxt   = 1'b1;
                    rdata_nxt = TIMEOUT_RDATA;
                end else begin
                    cnt_nxt     = cnt + 8'd1;
                    mem_req_nxt = 1'b1;
                end
            end
            ST_RESP: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        busy_nxt = (state_nxt != ST_IDLE);
    end

    assign bus.busy      = busy_r;
    assign bus.ack       = ack_r;
    assign bus.err       = err_r;
    assign bus.rdata     = rdata_r;
    assign bus.mem_req   = mem_req_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_bsel  = mem_bsel_r;
    assign bus.mem_wdata = mem_wdata_r;

endmodule

// File: doc/minimig_bank_responder.md
# minimig_bank_responder

Memory-side consumer of the 8-bit one-hot bank select produced by the Minimig bank mapping logic. It accepts a bus access qualified by `bank[7:0]`, validates and encodes the bank, and issues one request to the physical memory controller. It then returns read data, a completion strobe and an error flag to the bus side. It sits between the Amiga address decode and the SDRAM/SRAM controller. It also enforces ROM write protection and a response timeout.

## Interface
Parameters:
- `TIMEOUT`, 255: maximum cycles `mem_req` may wait for `mem_ack` before an error completion; range 1..255.

Ports:
- `clk` in 1: system clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `req` in 1: single-cycle access strobe from the bus side.
- `bank` in 8: one-hot bank select. Bit 7 is kick, 6 kickext, 5 chip, 4 slow/kick1mb/cart, 3..0 chip blocks 3..0.
- `addr` in 18: word address within the 512 KB block (byte address bits 18:1).
- `we` in 1: write when high.
- `bsel` in 2: byte lanes {upper, lower}.
- `wdata` in 16: write data.
- `rom_wp` in 1: when high, writes to banks 7 and 6 are blocked.
- `busy` out 1: high whenever the FSM is not IDLE.
- `ack` out 1: one-cycle completion strobe.
- `err` out 1: valid with `ack`; high for an illegal bank, a protected write, or a timeout.
- `rdata` out 16: read data; valid with `ack` and held until the next `ack`.
- `mem_req` out 1: request to the memory controller; a level held until acknowledged.
- `mem_addr` out 21: {bank index[2:0], addr[17:0]}, i.e. physical byte address bits 21:1.
- `mem_we` out 1, `mem_bsel` out 2, `mem_wdata` out 16: registered copies of the captured request.
- `mem_ack` in 1: memory controller completion.
- `mem_rdata` in 16: read data; valid when `mem_ack` is high.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE + `req`: capture `addr`, `we`, `bsel`, `wdata` and the encoded bank.
  - Legal and not blocked: go to ACCESS and assert `mem_req`.
  - Illegal bank (zero bits or more than one bit set): go to RESP with `err`=1. No memory access.
  - Write to bank 7 or 6 with `rom_wp`=1: go to RESP with `err`=1. No memory access.
- Bank encoding: bit n maps to index n. Index forms `mem_addr[20:18]`.
- ACCESS: `mem_req`=1 and the `mem_*` fields are held stable.
  - When `mem_ack` is sampled high on a read, capture `mem_rdata` into `rdata` and go to RESP with `err`=0.
  - Timeout counter: 8-bit, cleared on entry to ACCESS, incremented each cycle without `mem_ack`.
  - When the count reaches `TIMEOUT`-1 with no `mem_ack`: go to RESP with `err`=1 and `rdata`=16'hFFFF.
  - If `mem_ack` and the timeout coincide, `mem_ack` wins.
- RESP: `ack`=1 for exactly one cycle, then return to IDLE.
- `req` in ACCESS or RESP is ignored and not queued. The bus side must wait for `busy`=0.
- `mem_ack` sampled in IDLE or RESP (late ack after a timeout) is ignored.
- `rdata` is unchanged by write completions and by illegal/protected completions.

## Timing
- All outputs are registered.
- Reset values: `busy`=0, `ack`=0, `err`=0, `rdata`=0, `mem_req`=0, `mem_addr`=0, `mem_we`=0, `mem_bsel`=0, `mem_wdata`=0; state IDLE; counter 0.
- Legal access, `req` at cycle T: `mem_req` and `busy` are high from T+1.
  - With `mem_ack` at cycle A (A ≥ T+1): `mem_req` is low at A+1 and `ack` is high at A+1.
  - Minimum latency is 2 cycles.
- Illegal or protected access: `ack` and `err` high at T+1. `mem_req` is never asserted.
- Timeout: `mem_req` high for exactly `TIMEOUT` cycles, then `ack`+`err` in the following cycle.
- `busy` falls in the cycle after `ack`. A new `req` is accepted in that same cycle.
- Reset asserted mid-ACCESS: `mem_req` drops immediately (asynchronously). No `ack` is issued.

## Structure
- Shared package `minimig_bank_pkg`:
  - FSM state enum.
  - Bank bit constants: BANK_KICK=7, BANK_KICKEXT=6, BANK_CHIP=5, BANK_SLOW=4.
  - `ROM_WP_MASK`=8'hC0.
  - Default timeout constant.
- Sub-module `minimig_bank_onehot_enc`: purely combinational, 8-bit one-hot to 3-bit index plus a `valid` flag (exactly one bit set).

## Test plan
- Read, `bank`=8'h08, `addr`=18'h00123, `mem_ack` 3 cycles after `mem_req` rises with `mem_rdata`=16'hBEEF -> `mem_addr`=21'h0C0123; `ack`=1, `err`=0, `rdata`=16'hBEEF one cycle after `mem_ack`.
- Write, `bank`=8'h80, `rom_wp`=1 -> `ack`+`err` at T+1, `mem_req` stays 0. Same write with `rom_wp`=0 -> `mem_req`=1, `mem_addr[20:18]`=3'd7, `mem_we`=1.
- `bank`=8'h00, then `bank`=8'h11 -> each gives `ack`+`err` at T+1, no memory request, `rdata` unchanged.
- `TIMEOUT`=4, no `mem_ack` -> `mem_req` high for 4 cycles, then `ack`+`err`, `rdata`=16'hFFFF. A late `mem_ack` afterwards produces no extra `ack`.
- `req` pulsed while `busy`=1 -> ignored; exactly one `mem_req` transaction and one `ack` occur.
- `reset` asserted 2 cycles into ACCESS -> all outputs return to reset values asynchronously. After release, a new read completes normally.
